mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_ctrl_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/rr_arb2.sv | 11 +
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the parity-protected memory arbiter:
// default bus widths and the controller FSM state encoding.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side command/response bus between the arbiter (master) and the
// parity memory (slave). The stored word carries its parity bit in the MSB.
interface mem_arbiter_if
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W:0]   mem_dout;

    modport master (
        output mem_write,
        output mem_read,
        output mem_addr,
        output mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_write,
        input  mem_read,
        input  mem_addr,
        input  mem_din,
        output mem_dout
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to
// whichever requester was not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       win
);

    assign win = (&req) ? ~last : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single parity-protected memory port and
// keeps a sticky record of the first read that failed the parity check.
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              parity_err,
    output logic [ADDR_W-1:0] err_addr,
    input  logic              err_clr,
    mem_arbiter_if.master     bus
);

    state_e            state;
    state_e            state_nxt;
    logic              last;
    logic              win;
    logic              owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              any_req;
    logic              accept;
    logic              par_bad;

    assign any_req = req0 | req1;
    assign accept  = (state == ST_IDLE) && any_req;

    rr_arb2 u_rr (
        .req  ({req1, req0}),
        .last (last),
        .win  (win)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (any_req) state_nxt = ST_CMD;
            ST_CMD:  state_nxt = lat_we ? ST_IDLE : ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reset leaves 'last' pointing at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            last      <= 1'b1;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner     <= win;
                last      <= win;
                lat_we    <= win ? we1    : we0;
                lat_addr  <= win ? addr1  : addr0;
                lat_wdata <= win ? wdata1 : wdata0;
            end
        end
    end

    // A stored word must have odd total parity; even parity flags a fault.
    assign par_bad = ~(^bus.mem_dout);

    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            parity_err <= 1'b0;
            err_addr   <= '0;
        end else if ((state == ST_RESP) && par_bad) begin
            parity_err <= 1'b1;
            if (!parity_err) err_addr <= lat_addr;
        end
    end

    assign gnt0    = (state == ST_CMD)  && !owner;
    assign gnt1    = (state == ST_CMD)  &&  owner;
    assign rvalid0 = (state == ST_RESP) && !owner;
    assign rvalid1 = (state == ST_RESP) &&  owner;
    assign rdata   = (state == ST_RESP) ? bus.mem_dout[DATA_W-1:0] : '0;

    assign bus.mem_write = (state == ST_CMD) &&  lat_we;
    assign bus.mem_read  = (state == ST_CMD) && !lat_we;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_din   = lat_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          err_clr = 1'b0;
    logic          gnt0, gnt1, rvalid0, rvalid1, parity_err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] err_addr;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata      (rdata),
        .parity_err (parity_err),
        .err_addr   (err_addr),
        .err_clr    (err_clr),
        .bus        (bus)
    );

    initial forever #5 clk = ~clk;

    // Behavioural parity memory; fault_next corrupts the parity bit of the next read.
    logic          fault_next = 1'b0;
    logic [DW:0]   mem_word [logic [AW-1:0]];

    function automatic logic [DW:0] encode(input logic [DW-1:0] d);
        return {~(^d), d};
    endfunction

    function automatic logic [DW-1:0] init_data(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 8'h3C;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_write) mem_word[bus.mem_addr] = encode(bus.mem_din);
        if (bus.mem_read)
            bus.mem_dout <= (mem_word.exists(bus.mem_addr) ? mem_word[bus.mem_addr]
                             : encode(init_data(bus.mem_addr))) ^ {fault_next, {DW{1'b0}}};
    end

    // Transaction model: an accepted request occupies the port for a command
    // cycle, plus a response cycle for reads.
    bit            m_busy = 0, m_who = 0, m_we = 0, m_last = 1, m_perr = 0;
    int            m_k = 0;
    logic [AW-1:0] m_addr = '0, m_eaddr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] shadow [logic [AW-1:0]];
    bit            g0 = 0, g1 = 0;
    bit            checking = 0;
    int            vectors = 0, miscompares = 0;

    function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
        return shadow.exists(a) ? shadow[a] : init_data(a);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        bit cmd_ph  = m_busy && (m_k == 1);
        bit resp_ph = m_busy && (m_k == 2);
        if (!checking) return;
        cmp("gnt0", gnt0, cmd_ph && !m_who);
        cmp("gnt1", gnt1, cmd_ph && m_who);
        cmp("mem_write", bus.mem_write, cmd_ph && m_we);
        cmp("mem_read", bus.mem_read, cmd_ph && !m_we);
        if (cmd_ph) cmp("mem_addr", bus.mem_addr, m_addr);
        if (cmd_ph && m_we) cmp("mem_din", bus.mem_din, m_wdata);
        cmp("rvalid0", rvalid0, resp_ph && !m_who);
        cmp("rvalid1", rvalid1, resp_ph && m_who);
        if (resp_ph) cmp("rdata", rdata, shadow_rd(m_addr));
        cmp("parity_err", parity_err, m_perr);
        cmp("err_addr", err_addr, m_eaddr);
    endtask

    task automatic model_advance();
        bit cmd_ph  = m_busy && (m_k == 1);
        bit resp_ph = m_busy && (m_k == 2);
        g0 = cmd_ph && !m_who;
        g1 = cmd_ph && m_who;
        if (cmd_ph && m_we) shadow[m_addr] = m_wdata;
        if (rst) begin
            m_busy = 0; m_k = 0; m_last = 1; m_perr = 0; m_eaddr = '0;
            return;
        end
        if (err_clr) begin
            m_perr = 0; m_eaddr = '0;
        end else if (resp_ph && ((^bus.mem_dout) == 1'b0)) begin
            if (!m_perr) m_eaddr = m_addr;
            m_perr = 1;
        end
        if (!m_busy) begin
            if (req0 || req1) begin
                m_who   = (req0 && req1) ? !m_last : req1;
                m_last  = m_who;
                m_we    = m_who ? we1 : we0;
                m_addr  = m_who ? addr1 : addr0;
                m_wdata = m_who ? wdata1 : wdata0;
                m_busy  = 1;
                m_k     = 1;
            end
        end else if (m_k == 1 && !m_we) begin
            m_k = 2;
        end else begin
            m_busy = 0;
        end
    endtask

    // Called with clk low and inputs already driven; returns at the next falling edge.
    task automatic step();
        #2;
        check_cycle();
        model_advance();
        @(negedge clk);
    endtask

    int order[$];
    int exp_order[4] = '{0, 1, 0, 1};
    bit p0 = 0, p1 = 0;

    initial begin
        step();
        checking = 1;
        step();
        rst = 0;
        #2;
        cmp("rst_gnt0", gnt0, 0);
        cmp("rst_mem_write", bus.mem_write, 0);
        cmp("rst_parity_err", parity_err, 0);

        req0 = 1; we0 = 1; addr0 = 16'h0010; wdata0 = 8'hA5;
        step();
        req0 = 0;
        #2;
        cmp("wr_gnt0", gnt0, 1);
        cmp("wr_mem_write", bus.mem_write, 1);
        cmp("wr_mem_din", bus.mem_din, 8'hA5);
        cmp("wr_mem_addr", bus.mem_addr, 16'h0010);
        step();
        #2;
        cmp("wr_idle_gnt0", gnt0, 0);
        cmp("wr_idle_mem_write", bus.mem_write, 0);

        req1 = 1; we1 = 0; addr1 = 16'h0010;
        step();
        req1 = 0;
        #2;
        cmp("rd_gnt1", gnt1, 1);
        cmp("rd_mem_read", bus.mem_read, 1);
        step();
        #2;
        cmp("rd_rvalid1", rvalid1, 1);
        cmp("rd_rdata", rdata, 8'hA5);
        cmp("rd_parity_err", parity_err, 0);
        step();

        req0 = 1; we0 = 1; addr0 = 16'h0020; wdata0 = 8'h11;
        req1 = 1; we1 = 1; addr1 = 16'h0021; wdata1 = 8'h22;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (gnt0) order.push_back(0);
            if (gnt1) order.push_back(1);
            step();
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < 4; i++)
            cmp($sformatf("order%0d", i), (i < order.size()) ? order[i] : 32'hFFFF, exp_order[i]);

        req0 = 1; we0 = 0; addr0 = 16'h0040;
        step();
        req0 = 0; fault_next = 1;
        step();
        fault_next = 0;
        step();
        #2;
        cmp("fault1_parity_err", parity_err, 1);
        cmp("fault1_err_addr", err_addr, 16'h0040);
        req1 = 1; we1 = 0; addr1 = 16'h0050;
        step();
        req1 = 0; fault_next = 1;
        step();
        fault_next = 0;
        step();
        #2;
        cmp("fault2_parity_err", parity_err, 1);
        cmp("fault2_err_addr", err_addr, 16'h0040);
        err_clr = 1;
        step();
        err_clr = 0;
        #2;
        cmp("clr_parity_err", parity_err, 0);
        cmp("clr_err_addr", err_addr, 16'h0000);

        req0 = 1; we0 = 0; addr0 = 16'h0040;
        step();
        req0 = 0; fault_next = 1;
        step();
        fault_next = 0; err_clr = 1;
        step();
        err_clr = 0;
        #2;
        cmp("clr_wins_parity_err", parity_err, 0);

        req1 = 1; we1 = 0; addr1 = 16'h0010;
        step();
        req1 = 0; rst = 1;
        step();
        rst = 0;
        #2;
        cmp("abort_rvalid1", rvalid1, 0);
        cmp("abort_mem_read", bus.mem_read, 0);
        cmp("abort_gnt1", gnt1, 0);
        step();

        for (int c = 0; c < 3000; c++) begin
            if (g0) p0 = 0;
            if (g1) p1 = 0;
            if (!p0 && $urandom_range(0, 3) == 0) begin
                p0 = 1; we0 = $urandom_range(0, 1);
                addr0 = AW'($urandom_range(0, 15)); wdata0 = DW'($urandom);
            end else if (p0 && $urandom_range(0, 19) == 0) p0 = 0;
            if (!p1 && $urandom_range(0, 3) == 0) begin
                p1 = 1; we1 = $urandom_range(0, 1);
                addr1 = AW'($urandom_range(0, 15)); wdata1 = DW'($urandom);
            end else if (p1 && $urandom_range(0, 19) == 0) p1 = 0;
            req0 = p0; req1 = p1;
            rst        = ($urandom_range(0, 149) == 0);
            err_clr    = ($urandom_range(0, 24) == 0);
            fault_next = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
